// File: rtl/fetch_responder_pkg.sv
// rtl/fetch_responder_pkg.sv - shared rv32 fetch/decode types and constants
package fetch_responder_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {NORMAL, HOLD} fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_responder.sv
// rtl/fetch_responder.sv - aligns sync-read imem data with its pc for decode, with stall hold and flush bubbles
module fetch_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] NOP_INSTR = fetch_responder_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cur_pc,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc4,
    output logic              id_valid,
    output logic              id_misaligned
);
    import fetch_responder_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         v_q, v_d;
    logic [31:0]  hold_q, hold_d;
    if_id_t       bundle;

    assign imem_addr = cur_pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            pc_q    <= 32'd0;
            v_q     <= 1'b0;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            v_q     <= v_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        v_d     = v_q;
        hold_d  = hold_q;
        if (flush) begin
            v_d     = 1'b0;
            pc_d    = cur_pc;
            state_d = NORMAL;
        end else if (stall) begin
            // Capture only on stall entry: the memory output moves on while the PC is frozen.
            if (state_q == NORMAL && v_q) begin
                hold_d  = imem_rdata;
                state_d = HOLD;
            end
        end else begin
            pc_d    = cur_pc;
            v_d     = 1'b1;
            state_d = NORMAL;
        end
    end

    always_comb begin
        bundle.valid = v_q;
        bundle.pc    = pc_q;
        bundle.pc4   = pc_q + 32'd4;
        bundle.instr = NOP_INSTR;
        if (v_q) begin
            bundle.instr = (state_q == HOLD) ? hold_q : imem_rdata;
        end
    end

    assign id_instr      = bundle.instr;
    assign id_pc         = bundle.pc;
    assign id_pc4        = bundle.pc4;
    assign id_valid      = bundle.valid;
    assign id_misaligned = bundle.valid && (bundle.pc[1:0] != 2'b00);

endmodule
